// File: rtl/lens_link_pkg.sv
// Shared constants and types for the host <-> lens-control serial link.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: frame header bytes, checksum seed, one-hot responder states,
// response-byte index type, status snapshot struct and checksum helper.
package lens_link_pkg;

    localparam logic [7:0] REQ_HDR  = 8'h77;
    localparam logic [7:0] RSP_HDR  = 8'h55;
    localparam logic [7:0] CHK_SEED = 8'hAA;

    // One-hot responder states
    typedef enum logic [7:0] {
        ST_HUNT      = 8'b0000_0001,
        ST_GET_C1    = 8'b0000_0010,
        ST_GET_C2    = 8'b0000_0100,
        ST_GET_V     = 8'b0000_1000,
        ST_CHECK     = 8'b0001_0000,
        ST_DELAY     = 8'b0010_0000,
        ST_SEND      = 8'b0100_0000,
        ST_WAIT_DONE = 8'b1000_0000
    } lens_state_e;

    // Index of the response byte being sent: 0 = header, 1..4 = D1..D4
    typedef logic [2:0] rsp_idx_t;
    localparam rsp_idx_t RSP_LAST = 3'd4;

    // Status bytes frozen for the duration of one response
    typedef struct packed {
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
    } rsp_snap_t;

    // Expected request check byte for a given C1/C2 pair
    function automatic logic [7:0] req_chk(input logic [7:0] c1, input logic [7:0] c2);
        return CHK_SEED ^ c1 ^ c2;
    endfunction

endpackage

// File: rtl/lens_gap_timer.sv
// Down-counting interval timer: expired is high once LIMIT enabled cycles have elapsed since clr.
// Latency: clr takes effect on the next clock; expired is combinational from the count.
// Backpressure: none; counter saturates at zero and holds until cleared.
//
// Ports: clk, rst (async, active-high); clr reloads the count; en decrements
// it by one per cycle; expired flags a zero count.
module lens_gap_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned     W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    // Loaded with LIMIT-1 so that expired is seen in the LIMIT-th counted cycle
    localparam logic [W-1:0]    LOAD = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= LOAD;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/lens_ctrl_responder.sv
// Lens-control request parser and status responder (4-byte request in, 5-byte status out).
// Latency: cmd_valid/frame_err one cycle after the last request byte; first tx_wr RESP_DELAY cycles after cmd_valid.
// Backpressure: each response byte waits for tx_done; rx bytes arriving while responding are dropped.
//
// Ports: rx_data/rx_valid from the UART receiver; tx_data/tx_wr/tx_done to the
// UART transmitter; zoom_pos and *_lim/*_sta status inputs; cmd_* decoded
// request fields with cmd_valid; frame_err on bad format/checksum; busy while
// a frame is in progress.
module lens_ctrl_responder
    import lens_link_pkg::*;
#(
    parameter int unsigned GAP_TIMEOUT = 20000,
    parameter int unsigned RESP_DELAY  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_done,
    input  logic [7:0] zoom_pos,
    input  logic [1:0] view_lim,
    input  logic [1:0] foc_lim,
    input  logic [1:0] iris_lim,
    input  logic [1:0] view_sw_sta,
    input  logic [1:0] foc_sta,
    input  logic       touwu_sta,
    output logic       cmd_valid,
    output logic [1:0] cmd_self_check,
    output logic [1:0] cmd_video_sw_sta,
    output logic [1:0] cmd_focus_sta,
    output logic       cmd_touwu,
    output logic [7:0] cmd_pre_view,
    output logic       frame_err,
    output logic       busy
);

    lens_state_e state_q, state_nx;
    rsp_idx_t    idx_q, idx_nx;

    // C1[7] is always zero for an accepted C1, so only the low 7 bits are kept
    logic [6:0]  c1_q;
    logic [7:0]  c2_q;
    logic        chk_ok_q, chk_ok_nx;
    rsp_snap_t   snap_q, snap_in;

    logic        c1_ld, c2_ld, cmd_ld, err_set;
    logic        frame_good;
    logic [7:0]  rsp_byte;

    logic        in_get, in_dly;
    logic        gap_expired, dly_expired;

    // ------------------------------------------------------------------
    // Timers
    // ------------------------------------------------------------------
    assign in_get = (state_q == ST_GET_C1) || (state_q == ST_GET_C2) || (state_q == ST_GET_V);
    // The delay count runs through CHECK so the first tx_wr lands exactly
    // RESP_DELAY cycles after the cmd_valid cycle, even for RESP_DELAY = 1.
    assign in_dly = (state_q == ST_CHECK) || (state_q == ST_DELAY);

    lens_gap_timer #(.LIMIT(GAP_TIMEOUT)) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_get || rx_valid),
        .en      (in_get),
        .expired (gap_expired)
    );

    lens_gap_timer #(.LIMIT(RESP_DELAY)) u_dly_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_dly),
        .en      (in_dly),
        .expired (dly_expired)
    );

    // ------------------------------------------------------------------
    // Checksum, status snapshot and response-byte mux
    // ------------------------------------------------------------------
    assign frame_good = (rx_data == req_chk({1'b0, c1_q}, c2_q));

    always_comb begin
        snap_in.d1 = {2'b11, view_lim, foc_lim, iris_lim};
        snap_in.d2 = zoom_pos;
        snap_in.d3 = {3'b000, touwu_sta, foc_sta, view_sw_sta};
    end

    always_comb begin
        rsp_byte = RSP_HDR;
        case (idx_nx)
            3'd1:    rsp_byte = snap_q.d1;
            3'd2:    rsp_byte = snap_q.d2;
            3'd3:    rsp_byte = snap_q.d3;
            3'd4:    rsp_byte = snap_q.d1 ^ snap_q.d2 ^ snap_q.d3;
            default: rsp_byte = RSP_HDR;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx  = state_q;
        idx_nx    = idx_q;
        chk_ok_nx = chk_ok_q;
        c1_ld     = 1'b0;
        c2_ld     = 1'b0;
        cmd_ld    = 1'b0;
        err_set   = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (rx_valid && (rx_data == REQ_HDR)) begin
                    state_nx = ST_GET_C1;
                end
            end

            ST_GET_C1: begin
                if (rx_valid) begin
                    if (rx_data[7]) begin
                        err_set  = 1'b1;
                        state_nx = ST_HUNT;
                    end else begin
                        c1_ld    = 1'b1;
                        state_nx = ST_GET_C2;
                    end
                end else if (gap_expired) begin
                    state_nx = ST_HUNT;
                end
            end

            ST_GET_C2: begin
                if (rx_valid) begin
                    c2_ld    = 1'b1;
                    state_nx = ST_GET_V;
                end else if (gap_expired) begin
                    state_nx = ST_HUNT;
                end
            end

            ST_GET_V: begin
                // Verdict is registered here so cmd_valid/frame_err are
                // flops that are high during the CHECK cycle.
                if (rx_valid) begin
                    chk_ok_nx = frame_good;
                    cmd_ld    = frame_good;
                    err_set   = !frame_good;
                    state_nx  = ST_CHECK;
                end else if (gap_expired) begin
                    state_nx = ST_HUNT;
                end
            end

            ST_CHECK: begin
                idx_nx = '0;
                if (!chk_ok_q) begin
                    state_nx = ST_HUNT;
                end else if (dly_expired) begin
                    state_nx = ST_SEND;
                end else begin
                    state_nx = ST_DELAY;
                end
            end

            ST_DELAY: begin
                if (dly_expired) begin
                    state_nx = ST_SEND;
                end
            end

            ST_SEND: begin
                state_nx = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (idx_q == RSP_LAST) begin
                        state_nx = ST_HUNT;
                    end else begin
                        idx_nx   = idx_q + 3'd1;
                        state_nx = ST_SEND;
                    end
                end
            end

            default: begin
                state_nx = ST_HUNT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_HUNT;
            idx_q            <= '0;
            c1_q             <= '0;
            c2_q             <= '0;
            chk_ok_q         <= 1'b0;
            snap_q           <= '0;
            cmd_valid        <= 1'b0;
            frame_err        <= 1'b0;
            cmd_self_check   <= '0;
            cmd_video_sw_sta <= '0;
            cmd_focus_sta    <= '0;
            cmd_touwu        <= 1'b0;
            cmd_pre_view     <= '0;
            tx_wr            <= 1'b0;
            tx_data          <= '0;
            busy             <= 1'b0;
        end else begin
            state_q   <= state_nx;
            idx_q     <= idx_nx;
            chk_ok_q  <= chk_ok_nx;
            cmd_valid <= cmd_ld;
            frame_err <= err_set;

            if (c1_ld) begin
                c1_q <= rx_data[6:0];
            end
            if (c2_ld) begin
                c2_q <= rx_data;
            end

            if (cmd_ld) begin
                cmd_self_check   <= c1_q[1:0];
                cmd_video_sw_sta <= c1_q[3:2];
                cmd_focus_sta    <= c1_q[5:4];
                cmd_touwu        <= c1_q[6];
                cmd_pre_view     <= c2_q;
            end

            // Status is frozen once per response, at the CHECK cycle
            if (state_q == ST_CHECK) begin
                snap_q <= snap_in;
            end

            tx_wr <= (state_nx == ST_SEND);
            if (state_nx == ST_SEND) begin
                tx_data <= rsp_byte;
            end

            busy <= (state_nx != ST_HUNT);
        end
    end

endmodule

// File: tb/tb_lens_ctrl_responder.sv
// Directed bench for lens_ctrl_responder with a simple UART transmitter model.
// Latency: UART model raises tx_done three cycles after each tx_wr.
// Backpressure: UART model accepts one byte at a time.
module tb_lens_ctrl_responder;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_done;
    logic [7:0] zoom_pos;
    logic [1:0] view_lim, foc_lim, iris_lim, view_sw_sta, foc_sta;
    logic       touwu_sta;
    logic       cmd_valid;
    logic [1:0] cmd_self_check, cmd_video_sw_sta, cmd_focus_sta;
    logic       cmd_touwu;
    logic [7:0] cmd_pre_view;
    logic       frame_err;
    logic       busy;

    lens_ctrl_responder dut (
        .clk              (clk),
        .rst              (rst),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .tx_data          (tx_data),
        .tx_wr            (tx_wr),
        .tx_done          (tx_done),
        .zoom_pos         (zoom_pos),
        .view_lim         (view_lim),
        .foc_lim          (foc_lim),
        .iris_lim         (iris_lim),
        .view_sw_sta      (view_sw_sta),
        .foc_sta          (foc_sta),
        .touwu_sta        (touwu_sta),
        .cmd_valid        (cmd_valid),
        .cmd_self_check   (cmd_self_check),
        .cmd_video_sw_sta (cmd_video_sw_sta),
        .cmd_focus_sta    (cmd_focus_sta),
        .cmd_touwu        (cmd_touwu),
        .cmd_pre_view     (cmd_pre_view),
        .frame_err        (frame_err),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------
    // Event logs and UART transmitter model (sampled on the falling edge)
    // ------------------------------------------------------------------
    int         cv_cnt = 0, fe_cnt = 0, cv_cyc = -1, fe_cyc = -1;
    int         busy_fall_cyc = -1, done_seen = 0, pend = 0, stab_err = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] cur_tx = 8'h00;
    logic [7:0] tx_log[$];
    int         tx_cyc_log[$];
    int         done_cyc_log[$];

    always @(negedge clk) begin
        if (cmd_valid) begin cv_cnt++; cv_cyc = cyc; end
        if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
        tx_done = 1'b0;
        if (rst) begin
            pend = 0;
        end else if (pend > 0) begin
            if (tx_data !== cur_tx) stab_err++;
            pend--;
            if (pend == 0) begin
                tx_done = 1'b1;
                done_seen++;
                done_cyc_log.push_back(cyc);
            end
        end
        if (tx_wr) begin
            tx_log.push_back(tx_data);
            tx_cyc_log.push_back(cyc);
            cur_tx = tx_data;
            pend = 3;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int total = 0, bad = 0;
    int tx_base = 0, done_base = 0, cv_base = 0, fe_base = 0, last_rx_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        tx_base   = tx_log.size();
        done_base = done_cyc_log.size();
        cv_base   = cv_cnt;
        fe_base   = fe_cnt;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        last_rx_cyc = cyc;
    endtask

    task automatic send_frame(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] v);
        send_byte(8'h77);
        send_byte(c1);
        send_byte(c2);
        send_byte(v);
    endtask

    task automatic set_status(input logic [7:0] z, input logic [1:0] vl, input logic [1:0] fl,
                              input logic [1:0] il, input logic tw, input logic [1:0] fs,
                              input logic [1:0] vs);
        zoom_pos = z; view_lim = vl; foc_lim = fl; iris_lim = il;
        touwu_sta = tw; foc_sta = fs; view_sw_sta = vs;
    endtask

    task automatic check_cmd(input string tag, input logic tw, input logic [1:0] fs,
                             input logic [1:0] vs, input logic [1:0] sc, input logic [7:0] pv);
        chk({tag, "_touwu"}, cmd_touwu, tw);
        chk({tag, "_focus"}, cmd_focus_sta, fs);
        chk({tag, "_video"}, cmd_video_sw_sta, vs);
        chk({tag, "_selfchk"}, cmd_self_check, sc);
        chk({tag, "_preview"}, cmd_pre_view, pv);
    endtask

    // Waits for a full response, then checks bytes, turnaround, inter-byte spacing and busy release
    task automatic expect_resp(input string tag, input logic [39:0] exp);
        int n = 0;
        while (((tx_log.size() - tx_base) < 5 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_ntx"}, tx_log.size() - tx_base, 5);
        if ((tx_log.size() - tx_base) >= 5 && (done_cyc_log.size() - done_base) >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("%s_byte%0d", tag, i), tx_log[tx_base + i], exp[39 - 8*i -: 8]);
            end
            chk({tag, "_turnaround"}, tx_cyc_log[tx_base] - cv_cyc, 32);
            for (int i = 1; i < 5; i++) begin
                chk($sformatf("%s_gap%0d", tag, i), tx_cyc_log[tx_base + i],
                    done_cyc_log[done_base + i - 1] + 1);
            end
            chk({tag, "_busy_fall"}, busy_fall_cyc, done_cyc_log[done_base + 4] + 1);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        rst = 1'b1;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        set_status(8'h40, 2'b01, 2'b10, 2'b00, 1'b1, 2'b01, 2'b10);
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        check_cmd("rst", 1'b0, 2'b00, 2'b00, 2'b00, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Good frame
        mark();
        send_frame(8'h25, 8'h50, 8'hDF);
        repeat (3) @(negedge clk);
        chk("t1_cv_n", cv_cnt - cv_base, 1);
        chk("t1_cv_lat", cv_cyc, last_rx_cyc);
        check_cmd("t1", 1'b0, 2'b10, 2'b01, 2'b01, 8'h50);
        expect_resp("t1", 40'h55_D8_40_16_8E);
        chk("t1_fe_n", fe_cnt - fe_base, 0);

        // Bad checksum
        mark();
        send_frame(8'h25, 8'h50, 8'h00);
        repeat (60) @(negedge clk);
        chk("t2_fe_n", fe_cnt - fe_base, 1);
        chk("t2_fe_lat", fe_cyc, last_rx_cyc);
        chk("t2_cv_n", cv_cnt - cv_base, 0);
        chk("t2_ntx", tx_log.size() - tx_base, 0);
        chk("t2_busy", busy, 0);

        // Noise then bad C1, then a good frame
        mark();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h77);
        send_byte(8'hA5);
        repeat (5) @(negedge clk);
        chk("t3_fe_n", fe_cnt - fe_base, 1);
        chk("t3_fe_lat", fe_cyc, last_rx_cyc);
        chk("t3_cv_n", cv_cnt - cv_base, 0);
        chk("t3_busy", busy, 0);
        mark();
        send_frame(8'h25, 8'h50, 8'hDF);
        expect_resp("t3", 40'h55_D8_40_16_8E);
        chk("t3_cv_good", cv_cnt - cv_base, 1);

        // Inter-byte gap timeout
        mark();
        send_byte(8'h77);
        send_byte(8'h25);
        repeat (20000) @(negedge clk);
        send_byte(8'h50);
        send_byte(8'hDF);
        repeat (60) @(negedge clk);
        chk("t4_cv_n", cv_cnt - cv_base, 0);
        chk("t4_fe_n", fe_cnt - fe_base, 0);
        chk("t4_ntx", tx_log.size() - tx_base, 0);
        chk("t4_busy", busy, 0);
        mark();
        send_frame(8'h25, 8'h50, 8'hDF);
        expect_resp("t4", 40'h55_D8_40_16_8E);

        // Bytes during the response are dropped; status frozen at CHECK
        mark();
        send_frame(8'h25, 8'h50, 8'hDF);
        n = 0;
        while (tx_log.size() == tx_base && n < 200) begin
            @(negedge clk);
            n++;
        end
        zoom_pos = 8'h99;
        send_frame(8'h00, 8'h00, 8'hAA);
        expect_resp("t5", 40'h55_D8_40_16_8E);
        chk("t5_cv_n", cv_cnt - cv_base, 1);
        chk("t5_fe_n", fe_cnt - fe_base, 0);
        chk("t5_preview_kept", cmd_pre_view, 8'h50);
        mark();
        send_frame(8'h25, 8'h50, 8'hDF);
        expect_resp("t5b", 40'h55_D8_99_16_57);
        chk("t5b_cv_n", cv_cnt - cv_base, 1);

        // Reset in the middle of a response
        set_status(8'hE6, 2'b10, 2'b01, 2'b10, 1'b0, 2'b11, 2'b00);
        mark();
        send_frame(8'h4A, 8'h0E, 8'hEE);
        repeat (3) @(negedge clk);
        check_cmd("t6", 1'b1, 2'b00, 2'b10, 2'b10, 8'h0E);
        n = 0;
        while (done_seen < done_base + 2 && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_tx_wr", tx_wr, 0);
        chk("t6_rst_tx_data", tx_data, 0);
        chk("t6_rst_busy", busy, 0);
        check_cmd("t6_rst", 1'b0, 2'b00, 2'b00, 2'b00, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("t6_ntx_aborted", tx_log.size() - tx_base, 2);
        mark();
        send_frame(8'h4A, 8'h0E, 8'hEE);
        expect_resp("t6b", 40'h55_E6_E6_0C_0C);
        check_cmd("t6b", 1'b1, 2'b00, 2'b10, 2'b10, 8'h0E);

        chk("tx_data_stable", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
